// File: rtl/out_uart_tx_pkg.sv
// Shared definitions for the CPU-output UART transmitter: FSM states and
// nibble-to-ASCII-hex conversion.
package out_uart_tx_pkg;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] HEX_DIGIT_OFS = 8'h30;
    localparam logic [7:0] HEX_ALPHA_OFS = 8'h37;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (HEX_DIGIT_OFS + 8'(v)) : (HEX_ALPHA_OFS + 8'(v));
    endfunction

endpackage

// File: rtl/out_uart_tx_fifo_sync.sv
// Single-clock byte FIFO; q shows the head entry whenever not empty.
// A push while full is accepted only if a pop frees the slot on the same edge.
module fifo_sync #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       empty,
    output logic       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign q     = mem[rd_ptr];

    always_ff @(posedge clk) begin : mem_write
        if (wr_en) begin
            mem[wr_ptr] <= d;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin : ptr_count
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// Queues each change of the CPU output nibble as an ASCII hex character and
// serializes the queue on a UART 8N1 line.
module out_uart_tx
    import out_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cpu_out,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_t         state;
    logic [3:0]        prev;
    logic [7:0]        shift;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic              push_req;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [7:0]        fifo_q;
    logic              baud_done;

    assign push_req  = (cpu_out != prev);
    assign fifo_pop  = (state == U_IDLE) && !fifo_empty;
    assign baud_done = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy      = (state != U_IDLE) || !fifo_empty;

    fifo_sync #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (fifo_pop),
        .d     (hex_ascii(cpu_out)),
        .q     (fifo_q),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Change detect and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin : chg_detect
        if (!rst_n) begin
            prev     <= 4'h0;
            overflow <= 1'b0;
        end else begin
            if (push_req) begin
                prev <= cpu_out;
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame sequencer; tx is registered so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin : tx_fsm
        if (!rst_n) begin
            state   <= U_IDLE;
            shift   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                U_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift <= fifo_q;
                        baud  <= '0;
                        tx    <= 1'b0;
                        state <= U_START;
                    end
                end
                U_START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= U_DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                U_DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= U_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'(1);
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                U_STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= U_IDLE;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= U_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Scoreboard bench for out_uart_tx: expected bytes are queued at stimulus time
// and a line monitor decodes each UART frame and compares it.
module tb_out_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cpu_out;
    logic       tx;
    logic       busy;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frames = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];

    out_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_out  (cpu_out),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy !== 1'b0 || tx !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n >= budget), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Line monitor: samples every negedge of a frame, aborts on reset.
    logic [9:0] mon_bits;
    logic       mon_ok;
    logic       mon_abort;
    int         mon_n;
    int         mon_start;
    logic [7:0] mon_exp;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_ok    = 1'b1;
                mon_abort = 1'b0;
                mon_start = cyc;
                mon_n     = 0;
                mon_bits  = '0;
                while (mon_n < 40 && !mon_abort) begin
                    if (mon_n != 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        mon_abort = 1'b1;
                    end else if (mon_n % 4 == 0) begin
                        mon_bits[mon_n / 4] = tx;
                    end else if (tx !== mon_bits[mon_n / 4]) begin
                        mon_ok = 1'b0;
                    end
                    mon_n++;
                end
                if (!mon_abort) begin
                    frames++;
                    starts_q.push_back(mon_start);
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_ok = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {23'd0, mon_ok, mon_bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("frame", {23'd0, mon_ok, mon_bits[8:1]}, {23'd0, 1'b1, mon_exp});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int f0;

    initial begin : stimulus
        rst_n   = 1'b0;
        cpu_out = 4'h0;
        repeat (5) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // 1: quiet line with cpu_out held at zero
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("quiet", {29'd0, tx, busy, overflow}, 32'b100);
        end

        // 2: 0 -> 5, latency and frame length
        cpu_out = 4'h5;
        exp_q.push_back(8'h35);
        @(negedge clk);
        check("lat_tx_high", 32'(tx), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_tx_fall", 32'(tx), 32'd0);
        repeat (39) @(negedge clk);
        check("end_busy_stop", 32'(busy), 32'd1);
        check("end_tx_stop", 32'(tx), 32'd1);
        @(negedge clk);
        check("end_busy_fall", 32'(busy), 32'd0);
        wait_idle("t2", 100);

        // 3: 5 -> A
        cpu_out = 4'hA;
        exp_q.push_back(8'h41);
        @(negedge clk);
        wait_idle("t3", 100);

        // 4: burst of ten changes overruns the FIFO by one
        starts_q.delete();
        for (int v = 1; v <= 10; v++) begin
            cpu_out = 4'(v);
            if (v <= 9) exp_q.push_back(8'h30 + 8'(v));
            @(negedge clk);
            if (v == 9) check("ovf_before", 32'(overflow), 32'd0);
            if (v == 10) check("ovf_set", 32'(overflow), 32'd1);
        end
        wait_idle("t4", 1000);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("burst_frames", 32'(starts_q.size()), 32'd9);
        for (int i = 0; i + 1 < starts_q.size(); i++) begin
            check("burst_gap", 32'(starts_q[i + 1] - starts_q[i]), 32'd41);
        end

        // 5: reset during data bit 2 of a '3' frame
        cpu_out = 4'h3;
        exp_q.push_back(8'h33);
        repeat (15) @(negedge clk);
        check("pre_rst_tx_low", 32'(tx), 32'd0);
        f0 = frames;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h33);
        @(negedge clk);
        wait_idle("t5", 100);
        check("rst_frames", 32'(frames - f0), 32'd1);

        // 6: constant 7 produces exactly one frame
        f0 = frames;
        cpu_out = 4'h7;
        exp_q.push_back(8'h37);
        @(negedge clk);
        wait_idle("t6", 100);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            check("hold_quiet", {30'd0, tx, busy}, 32'b10);
        end
        check("hold_frames", 32'(frames - f0), 32'd1);
        check("hold_ovf", 32'(overflow), 32'd0);
        check("exp_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
